// File: rtl/lag_pl_status_tracker_pkg.sv
// lag_pl_status_tracker_pkg: shared PL lifecycle states and sticky error flag indices
package lag_pl_status_tracker_pkg;
    typedef enum logic [1:0] {PL_FREE, PL_ALLOC, PL_DRAIN} pl_state_t;
    localparam int ERR_UNDER = 0;
    localparam int ERR_OVER  = 1;
    localparam int ERR_PROTO = 2;
    typedef logic [2:0] output_port_t;
endpackage

// File: rtl/lag_pl_credit_fsm.sv
// lag_pl_credit_fsm: one PL's lifecycle state, downstream credit counter and error pulses
module lag_pl_credit_fsm
    import lag_pl_status_tracker_pkg::*;
#(
    parameter int buf_len = 4,
    localparam int cw = $clog2(buf_len + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc,
    input  logic          send,
    input  logic          tail,
    input  logic          credit,
    output logic          free,
    output logic          credit_ok,
    output logic [cw-1:0] credits,
    output logic [2:0]    err_pulse
);
    localparam logic [cw-1:0] full = cw'(buf_len);
    pl_state_t state;
    logic [cw-1:0] next_count;
    logic under, over, proto, next_full;
    always_comb begin
        under      = send && credits == '0;
        over       = credit && !send && credits == full;
        proto      = (alloc && state != PL_FREE) || (send && state != PL_ALLOC);
        next_count = under ? '0 : over ? full : credits - cw'(send) + cw'(credit);
        next_full  = next_count == full;
        err_pulse  = '0;
        err_pulse[ERR_UNDER] = under;
        err_pulse[ERR_OVER]  = over;
        err_pulse[ERR_PROTO] = proto;
    end
    // The release decision looks at next_count so a same-cycle credit can skip DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PL_FREE;
            credits <= full;
        end else begin
            credits <= next_count;
            case (state)
                PL_FREE:  state <= alloc ? PL_ALLOC : PL_FREE;
                PL_ALLOC: state <= !(send && tail) ? PL_ALLOC : next_full ? PL_FREE : PL_DRAIN;
                PL_DRAIN: state <= next_full ? PL_FREE : PL_DRAIN;
                default:  state <= PL_FREE;
            endcase
        end
    end
    assign free      = state == PL_FREE;
    assign credit_ok = credits != '0;
endmodule

// File: rtl/lag_pl_status_tracker.sv
// lag_pl_status_tracker: per-port, per-PL credit and lifecycle tracking for the PL allocator
module lag_pl_status_tracker
    import lag_pl_status_tracker_pkg::*;
#(
    parameter int np = 5,
    parameter int nv = 4,
    parameter int buf_len = 4,
    localparam int cw = $clog2(buf_len + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [np-1:0][nv-1:0]          pl_allocated,
    input  logic [np-1:0][nv-1:0]          flit_sent,
    input  logic [np-1:0][nv-1:0]          flit_tail,
    input  logic [np-1:0][nv-1:0]          credit_in,
    output logic [np-1:0][nv-1:0]          pl_status,
    output logic [np-1:0][nv-1:0]          pl_credit_ok,
    output logic [np-1:0][nv-1:0][cw-1:0]  pl_credits,
    output logic [2:0]                     err
);
    logic [np*nv-1:0][2:0] pulse;
    logic [2:0] pulse_any;
    for (genvar p = 0; p < np; p++) begin : g_port
        for (genvar v = 0; v < nv; v++) begin : g_pl
            lag_pl_credit_fsm #(.buf_len(buf_len)) u_fsm (
                .clk       (clk),
                .rst       (rst),
                .alloc     (pl_allocated[p][v]),
                .send      (flit_sent[p][v]),
                .tail      (flit_tail[p][v]),
                .credit    (credit_in[p][v]),
                .free      (pl_status[p][v]),
                .credit_ok (pl_credit_ok[p][v]),
                .credits   (pl_credits[p][v]),
                .err_pulse (pulse[p*nv+v])
            );
        end
    end
    always_comb begin
        pulse_any = '0;
        for (int i = 0; i < np*nv; i++) pulse_any |= pulse[i];
    end
    always_ff @(posedge clk) begin
        err <= rst ? '0 : err | pulse_any;
    end
endmodule

// File: tb/tb_lag_pl_status_tracker.sv
// tb_lag_pl_status_tracker: directed and random checks against an abstract PL ownership/credit model
module tb_lag_pl_status_tracker;
    localparam int NP = 5;
    localparam int NV = 4;
    localparam int BL = 4;
    localparam int CW = $clog2(BL + 1);
    typedef logic [NP-1:0][NV-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t pl_allocated = '0, flit_sent = '0, flit_tail = '0, credit_in = '0;
    vec_t pl_status, pl_credit_ok;
    logic [NP-1:0][NV-1:0][CW-1:0] pl_credits;
    logic [2:0] err;

    int n_vec = 0;
    int n_err = 0;

    // Model: a PL is available, or owned by an open packet, or waiting for credits.
    int   cred [NP][NV];
    bit   avail[NP][NV];
    bit   open [NP][NV];
    logic [2:0] err_m;

    lag_pl_status_tracker #(.np(NP), .nv(NV), .buf_len(BL)) dut (
        .clk(clk), .rst(rst),
        .pl_allocated(pl_allocated), .flit_sent(flit_sent),
        .flit_tail(flit_tail), .credit_in(credit_in),
        .pl_status(pl_status), .pl_credit_ok(pl_credit_ok),
        .pl_credits(pl_credits), .err(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t one(input int p, input int v);
        vec_t r;
        r = '0;
        r[p][v] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                cred[p][v] = BL; avail[p][v] = 1; open[p][v] = 0;
            end
        err_m = '0;
    endtask

    task automatic model_update(input vec_t a, input vec_t s, input vec_t t, input vec_t c);
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                if (s[p][v] && cred[p][v] == 0) err_m[0] = 1;
                else if (c[p][v] && !s[p][v] && cred[p][v] == BL) err_m[1] = 1;
                else cred[p][v] = cred[p][v] - int'(s[p][v]) + int'(c[p][v]);
                if (s[p][v]) begin
                    if (!open[p][v]) err_m[2] = 1;
                    else if (t[p][v]) open[p][v] = 0;
                end
                if (a[p][v]) begin
                    if (avail[p][v]) begin avail[p][v] = 0; open[p][v] = 1; end
                    else err_m[2] = 1;
                end
                if (!avail[p][v] && !open[p][v] && cred[p][v] == BL) avail[p][v] = 1;
            end
    endtask

    task automatic check(input string tag);
        vec_t st, ok;
        logic [NP-1:0][NV-1:0][CW-1:0] cr;
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                st[p][v] = avail[p][v];
                ok[p][v] = cred[p][v] != 0;
                cr[p][v] = CW'(cred[p][v]);
            end
        n_vec++;
        assert (pl_status === st) else begin
            n_err++; $error("FAIL %s status: got %h expected %h", tag, pl_status, st);
        end
        n_vec++;
        assert (pl_credit_ok === ok) else begin
            n_err++; $error("FAIL %s credit_ok: got %h expected %h", tag, pl_credit_ok, ok);
        end
        n_vec++;
        assert (pl_credits === cr) else begin
            n_err++; $error("FAIL %s credits: got %h expected %h", tag, pl_credits, cr);
        end
        n_vec++;
        assert (err === err_m) else begin
            n_err++; $error("FAIL %s err: got %b expected %b", tag, err, err_m);
        end
    endtask

    task automatic step(input vec_t a, input vec_t s, input vec_t t, input vec_t c, input string tag);
        pl_allocated = a; flit_sent = s; flit_tail = t; credit_in = c;
        model_update(a, s, t, c);
        @(posedge clk);
        #1;
        pl_allocated = '0; flit_sent = '0; flit_tail = '0; credit_in = '0;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(tag);
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_err++; $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    initial begin
        vec_t a, s, t, c;
        #1;
        do_reset("reset");
        for (int i = 0; i < 5; i++) step('0, '0, '0, '0, "idle");

        step(one(2,1), '0, '0, '0, "t2_alloc");
        expect_bit("t2_status_busy", pl_status[2][1], 1'b0);
        for (int i = 0; i < 3; i++) step('0, one(2,1), '0, '0, "t2_body");
        step('0, one(2,1), one(2,1), '0, "t2_tail");
        expect_bit("t2_drain_count0", pl_credits[2][1] == '0, 1'b1);
        step('0, '0, '0, '0, "t2_gap");
        for (int i = 0; i < 3; i++) step('0, '0, '0, one(2,1), "t2_credit");
        expect_bit("t2_still_drain", pl_status[2][1], 1'b0);
        step('0, '0, '0, one(2,1), "t2_last_credit");
        expect_bit("t2_freed", pl_status[2][1], 1'b1);

        step(one(0,0), '0, '0, '0, "t3_alloc");
        step('0, one(0,0), one(0,0), one(0,0), "t3_tail_credit");
        expect_bit("t3_free_no_drain", pl_status[0][0], 1'b1);
        expect_bit("t3_count_full", pl_credits[0][0] == CW'(BL), 1'b1);

        step('0, '0, '0, one(1,0), "t4_overflow");
        expect_bit("t4_err1", err[1], 1'b1);
        step(one(1,1), '0, '0, '0, "t4_alloc");
        for (int i = 0; i < 4; i++) step('0, one(1,1), '0, '0, "t4_drain_credits");
        step('0, one(1,1), '0, '0, "t4_underflow");
        expect_bit("t4_err0", err[0], 1'b1);

        step(one(3,0), '0, '0, '0, "t5_alloc");
        step(one(3,0), '0, '0, '0, "t5_realloc");
        expect_bit("t5_err2", err[2], 1'b1);
        step('0, one(3,1), one(3,1), '0, "t5_send_free");
        expect_bit("t5_stays_free", pl_status[3][1], 1'b1);

        do_reset("pre_random");
        for (int n = 0; n < 400; n++) begin
            a = '0; s = '0; t = '0; c = '0;
            for (int p = 0; p < NP; p++)
                for (int v = 0; v < NV; v++) begin
                    a[p][v] = avail[p][v] && $urandom_range(3) == 0;
                    s[p][v] = open[p][v] && cred[p][v] > 0 && $urandom_range(1) == 1;
                    t[p][v] = s[p][v] && $urandom_range(3) == 0;
                    c[p][v] = cred[p][v] < BL && $urandom_range(1) == 1;
                end
            step(a, s, t, c, "random");
        end

        do_reset("t6_reset");
        step(one(4,3), '0, '0, '0, "t6_alloc");
        step('0, one(4,3), '0, '0, "t6_body");
        step('0, one(4,3), '0, '0, "t6_body");
        step('0, one(4,3), one(4,3), '0, "t6_tail");
        expect_bit("t6_count1", pl_credits[4][3] == CW'(1), 1'b1);
        step('0, '0, '0, '0, "t6_drain");
        do_reset("t6_mid_reset");
        expect_bit("t6_status_back", pl_status[4][3], 1'b1);
        expect_bit("t6_count_back", pl_credits[4][3] == CW'(BL), 1'b1);
        step('0, '0, '0, one(4,3), "t6_late_credit");
        expect_bit("t6_late_overflow", err[1], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
